// File: rtl/debounce_edge_detector_pkg.sv
// Shared types for the debounce / edge detector block.
// Holds the 2-bit FSM state encoding used by debounce_edge_detector.
package debounce_edge_detector_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'b00,
        CONFIRM_HIGH = 2'b01,
        IDLE_HIGH    = 2'b10,
        CONFIRM_LOW  = 2'b11
    } state_t;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer chain for an asynchronous single-bit level.
// Output is the last flop of a STAGES-deep shift chain.
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_edge_detector.sv
// Debounced level plus one-cycle rising/falling pulses from a raw input.
// Optional rejected-glitch counter: DEBOUNCE_EDGE_DETECTOR_GLITCH_COUNT_EN.
module debounce_edge_detector
    import debounce_edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   data_in,
    output logic                   stable,
    output logic                   rising,
    output logic                   falling,
    output logic [COUNT_WIDTH-1:0] glitch_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic          sample;
    state_t        state;
    logic [CW-1:0] cnt;

    synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (data_in),
        .q    (sample)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            stable  <= 1'b0;
            rising  <= 1'b0;
            falling <= 1'b0;
        end else begin
            rising  <= 1'b0;
            falling <= 1'b0;
            unique case (state)
                IDLE_LOW: begin
                    if (sample) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state  <= IDLE_HIGH;
                            stable <= 1'b1;
                            rising <= 1'b1;
                        end else begin
                            state <= CONFIRM_HIGH;
                            cnt   <= ONE;
                        end
                    end
                end
                CONFIRM_HIGH: begin
                    // A full run has been seen; accept at this edge.
                    if (cnt == TARGET) begin
                        state  <= IDLE_HIGH;
                        cnt    <= '0;
                        stable <= 1'b1;
                        rising <= 1'b1;
                    end else if (sample) begin
                        cnt <= cnt + ONE;
                    end else begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end
                end
                IDLE_HIGH: begin
                    if (!sample) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state   <= IDLE_LOW;
                            stable  <= 1'b0;
                            falling <= 1'b1;
                        end else begin
                            state <= CONFIRM_LOW;
                            cnt   <= ONE;
                        end
                    end
                end
                CONFIRM_LOW: begin
                    if (cnt == TARGET) begin
                        state   <= IDLE_LOW;
                        cnt     <= '0;
                        stable  <= 1'b0;
                        falling <= 1'b1;
                    end else if (!sample) begin
                        cnt <= cnt + ONE;
                    end else begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EDGE_DETECTOR_GLITCH_COUNT_EN
    logic                   reject;
    logic [COUNT_WIDTH-1:0] gcnt;

    assign reject = (cnt != TARGET) &&
                    (((state == CONFIRM_HIGH) && !sample) ||
                     ((state == CONFIRM_LOW) && sample));

    always_ff @(posedge clock) begin
        if (reset) begin
            gcnt <= '0;
        end else if (reject && (gcnt != '1)) begin
            gcnt <= gcnt + COUNT_WIDTH'(1);
        end
    end

    assign glitch_count = gcnt;
`else
    assign glitch_count = '0;
`endif

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Randomized and directed bench for debounce_edge_detector.
// Reference model works on run lengths of synchronized samples.
module tb_debounce_edge_detector;

    localparam int SS  = 2;
    localparam int D   = 4;
    localparam int CWD = 8;
    localparam int SAT = (1 << CWD) - 1;
`ifdef DEBOUNCE_EDGE_DETECTOR_GLITCH_COUNT_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif

    logic           clock;
    logic           reset;
    logic           data_in;
    logic           stable;
    logic           rising;
    logic           falling;
    logic [CWD-1:0] glitch_count;

    int total;
    int bad;

    // reference model state
    logic [SS-1:0] m_sync;
    logic          m_stable;
    logic          m_rise;
    logic          m_fall;
    int            m_run;
    int            m_gl;

    debounce_edge_detector #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(D),
        .COUNT_WIDTH    (CWD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .stable      (stable),
        .rising      (rising),
        .falling     (falling),
        .glitch_count(glitch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle, advance the model across the edge, settle 1ns.
    task automatic tick(input logic d, input logic r);
        logic s;
        data_in = d;
        reset   = r;
        @(posedge clock);
        if (r) begin
            m_sync   = '0;
            m_stable = 1'b0;
            m_rise   = 1'b0;
            m_fall   = 1'b0;
            m_run    = 0;
            m_gl     = 0;
        end else begin
            s      = m_sync[SS-1];
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_run == D || (D == 1 && s != m_stable)) begin
                m_stable = ~m_stable;
                m_rise   = m_stable;
                m_fall   = ~m_stable;
                m_run    = 0;
            end else if (s != m_stable) begin
                m_run++;
            end else begin
                if (m_run > 0 && GEN && m_gl < SAT) m_gl++;
                m_run = 0;
            end
            m_sync = {m_sync[SS-2:0], d};
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        total++;
        if ({stable, rising, falling} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outs got=%b want=000",
                     {stable, rising, falling});
        end
        total++;
        if (glitch_count !== '0) begin
            bad++;
            $display("FAIL reset_gc got=%0d want=0", glitch_count);
        end
    endtask

    task automatic test_rise();
        int nf;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0);
        nf = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b0);
            if (falling) nf++;
            total++;
            if (stable !== (k >= SS + D)) begin
                bad++;
                $display("FAIL rise_stable k=%0d got=%b want=%b",
                         k, stable, (k >= SS + D));
            end
            total++;
            if (rising !== (k == SS + D)) begin
                bad++;
                $display("FAIL rise_pulse k=%0d got=%b want=%b",
                         k, rising, (k == SS + D));
            end
        end
        total++;
        if (nf != 0) begin
            bad++;
            $display("FAIL rise_nofall got=%0d want=0", nf);
        end
    endtask

    task automatic test_glitch();
        int np;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
        np = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            if (rising || falling || stable) np++;
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            if (rising || falling || stable) np++;
        end
        total++;
        if (np != 0) begin
            bad++;
            $display("FAIL glitch_quiet got=%0d want=0", np);
        end
        total++;
        if (glitch_count !== (GEN ? 8'd1 : 8'd0)) begin
            bad++;
            $display("FAIL glitch_gc got=%0d want=%0d",
                     glitch_count, GEN ? 1 : 0);
        end
    endtask

    task automatic test_saturate();
        int np;
        np = 0;
        for (int g = 0; g < 300; g++) begin
            tick(1'b1, 1'b0);
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
            tick(1'b0, 1'b0);
            if (stable || rising || falling) np++;
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
        total++;
        if (np != 0 || stable !== 1'b0) begin
            bad++;
            $display("FAIL sat_stable got=%0d/%b want=0/0", np, stable);
        end
        total++;
        if (glitch_count !== (GEN ? 8'd255 : 8'd0)) begin
            bad++;
            $display("FAIL sat_gc got=%0d want=%0d",
                     glitch_count, GEN ? 255 : 0);
        end
    endtask

    task automatic test_reset_abort();
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        total++;
        if ({stable, rising, falling} !== 3'b000 || glitch_count !== '0) begin
            bad++;
            $display("FAIL abort_outs got=%b gc=%0d want=000 gc=0",
                     {stable, rising, falling}, glitch_count);
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0);
            total++;
            if ({stable, rising} !== {1'(k >= SS + D), 1'(k == SS + D)}) begin
                bad++;
                $display("FAIL abort_rise k=%0d got=%b%b want=%b%b",
                         k, stable, rising, (k >= SS + D), (k == SS + D));
            end
        end
    endtask

    task automatic test_back_to_back();
        int nr, nf, nb;
        tick(1'b0, 1'b1);
        nr = 0;
        nf = 0;
        nb = 0;
        for (int i = 0; i < 24; i++) begin
            tick(i < 12, 1'b0);
            if (rising) nr++;
            if (falling) nf++;
            if (rising && falling) nb++;
        end
        total++;
        if (nr != 1 || nf != 1) begin
            bad++;
            $display("FAIL b2b_pulses got=%0d/%0d want=1/1", nr, nf);
        end
        total++;
        if (nb != 0 || stable !== 1'b0) begin
            bad++;
            $display("FAIL b2b_overlap got=%0d st=%b want=0 st=0", nb, stable);
        end
    endtask

    task automatic test_toggle();
        int np;
        tick(1'b0, 1'b1);
        np = 0;
        for (int i = 0; i < 40; i++) begin
            tick(i[0], 1'b0);
            if (stable || rising || falling) np++;
        end
        total++;
        if (np != 0) begin
            bad++;
            $display("FAIL toggle_quiet got=%0d want=0", np);
        end
    endtask

    task automatic test_random();
        logic d;
        int   hold;
        tick(1'b0, 1'b1);
        d = 1'b0;
        for (int n = 0; n < 400; n++) begin
            d    = ~d;
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                tick(d, ($urandom_range(0, 199) == 0));
                total++;
                if ({stable, rising, falling} !== {m_stable, m_rise, m_fall}
                    || glitch_count !== CWD'(m_gl)) begin
                    bad++;
                    $display("FAIL rand_model n=%0d got=%b gc=%0d want=%b gc=%0d",
                             n, {stable, rising, falling}, glitch_count,
                             {m_stable, m_rise, m_fall}, m_gl);
                end
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        data_in = 1'b0;
        m_sync  = '0;
        m_stable = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_run   = 0;
        m_gl    = 0;
        test_reset();
        test_rise();
        test_glitch();
        test_saturate();
        test_reset_abort();
        test_back_to_back();
        test_toggle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
